// File: rtl/gate_arbiter.sv
// gate_arbiter: two-lane round-robin arbiter in front of a single gate
// controller. A granted lane has its vehicle/PIN signals forwarded to the
// controller; the grant is released when the gate closes behind the vehicle,
// when the vehicle leaves, or when the lane sits in SERVE for too long.
module gate_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Veh_A,
    input  logic       Veh_B,
    input  logic [7:0] Pin_A,
    input  logic [7:0] Pin_B,
    input  logic       Cerrado,
    input  logic       Abierto,
    input  logic       Bloqueo,
    output logic       Vehiculo,
    output logic [7:0] Pin,
    output logic       Grant_A,
    output logic       Grant_B,
    output logic       Busy,
    output logic       Timeout
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SERVE = 4'b0010,
        S_PASS  = 4'b0100,
        S_LOCK  = 4'b1000
    } state_t;

    // Lane encoding for the round-robin pointer.
    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    // Counter value on which a SERVE grant expires, and the saturation ceiling.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_grant_a;
    logic             r_grant_b;
    logic             r_timeout;

    logic             w_gveh;
    logic [7:0]       w_gpin;

    // Signals of whichever lane currently holds the grant; zero when no grant.
    assign w_gveh = (r_grant_a & Veh_A) | (r_grant_b & Veh_B);
    assign w_gpin = r_grant_a ? Pin_A : (r_grant_b ? Pin_B : 8'h00);

    // Arbitration FSM: state, round-robin pointer, timeout counter, grants and
    // the timeout pulse all update together. Every path back to IDLE records
    // the served lane in r_last and drops both grants on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_last    <= LANE_B;
            r_cnt     <= '0;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (Veh_A && Veh_B) begin
                        r_state   <= S_SERVE;
                        r_grant_a <= (r_last == LANE_B);
                        r_grant_b <= (r_last == LANE_A);
                    end else if (Veh_A) begin
                        r_state   <= S_SERVE;
                        r_grant_a <= 1'b1;
                        r_grant_b <= 1'b0;
                    end else if (Veh_B) begin
                        r_state   <= S_SERVE;
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (Bloqueo) begin
                        r_state <= S_LOCK;
                        r_cnt   <= '0;
                    end else if (Abierto) begin
                        r_state <= S_PASS;
                        r_cnt   <= '0;
                    end else if (!w_gveh) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_last    <= r_grant_b ? LANE_B : LANE_A;
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_last    <= r_grant_b ? LANE_B : LANE_A;
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                S_PASS: begin
                    r_cnt <= '0;
                    if (Bloqueo) begin
                        r_state <= S_LOCK;
                    end else if (Cerrado && !Abierto) begin
                        r_state   <= S_IDLE;
                        r_last    <= r_grant_b ? LANE_B : LANE_A;
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b0;
                    end
                end
                S_LOCK: begin
                    // No timeout here: the lane stays held until the block clears.
                    r_cnt <= '0;
                    if (!Bloqueo && Abierto) begin
                        r_state <= S_PASS;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_grant_a <= 1'b0;
                    r_grant_b <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding to the gate controller: zero-latency mux of the granted lane,
    // with the PIN suppressed while the gate is passing a vehicle.
    always_comb begin
        Vehiculo = 1'b0;
        Pin      = 8'h00;
        case (r_state)
            S_SERVE, S_LOCK: begin
                Vehiculo = w_gveh;
                Pin      = w_gpin;
            end
            S_PASS: begin
                Vehiculo = w_gveh;
            end
            default: begin
                Vehiculo = 1'b0;
                Pin      = 8'h00;
            end
        endcase
    end

    assign Grant_A = r_grant_a;
    assign Grant_B = r_grant_b;
    assign Busy    = (r_state != S_IDLE);
    assign Timeout = r_timeout;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed testbench for gate_arbiter: each task drives one scenario and
// checks the outputs against hand-computed values.
module tb_gate_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Veh_A, Veh_B;
    logic [7:0] Pin_A, Pin_B;
    logic       Cerrado, Abierto, Bloqueo;
    logic       Vehiculo;
    logic [7:0] Pin;
    logic       Grant_A, Grant_B, Busy, Timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    gate_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Veh_A    (Veh_A),
        .Veh_B    (Veh_B),
        .Pin_A    (Pin_A),
        .Pin_B    (Pin_B),
        .Cerrado  (Cerrado),
        .Abierto  (Abierto),
        .Bloqueo  (Bloqueo),
        .Vehiculo (Vehiculo),
        .Pin      (Pin),
        .Grant_A  (Grant_A),
        .Grant_B  (Grant_B),
        .Busy     (Busy),
        .Timeout  (Timeout)
    );

    always #5 Clk = ~Clk;

    // Advance one clock edge and step just past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Veh_A = 1'b0; Veh_B = 1'b0; Pin_A = 8'h00; Pin_B = 8'h00;
        Cerrado = 1'b0; Abierto = 1'b0; Bloqueo = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        n_cmp++; if (Grant_A !== 1'b0) begin n_fail++; $display("FAIL reset_grant_a: got %b want 0", Grant_A); end
        n_cmp++; if (Grant_B !== 1'b0) begin n_fail++; $display("FAIL reset_grant_b: got %b want 0", Grant_B); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
        n_cmp++; if (Vehiculo !== 1'b0) begin n_fail++; $display("FAIL reset_vehiculo: got %b want 0", Vehiculo); end
        n_cmp++; if (Pin !== 8'h00) begin n_fail++; $display("FAIL reset_pin: got %h want 00", Pin); end
    endtask

    // Both lanes request from reset: A wins first, B wins after A times out.
    task automatic test_tie();
        Veh_A = 1'b1; Veh_B = 1'b1; Pin_A = 8'h11; Pin_B = 8'h22;
        tick();
        n_cmp++; if (Grant_A !== 1'b1) begin n_fail++; $display("FAIL tie_first_grant_a: got %b want 1", Grant_A); end
        n_cmp++; if (Grant_B !== 1'b0) begin n_fail++; $display("FAIL tie_first_grant_b: got %b want 0", Grant_B); end
        n_cmp++; if (Pin !== 8'h11) begin n_fail++; $display("FAIL tie_first_pin: got %h want 11", Pin); end
        repeat (15) tick();
        n_cmp++; if (Grant_A !== 1'b1) begin n_fail++; $display("FAIL tie_hold_grant_a: got %b want 1", Grant_A); end
        tick();
        n_cmp++; if (Grant_A !== 1'b0) begin n_fail++; $display("FAIL tie_release_grant_a: got %b want 0", Grant_A); end
        n_cmp++; if (Grant_B !== 1'b0) begin n_fail++; $display("FAIL tie_gap_grant_b: got %b want 0", Grant_B); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL tie_gap_busy: got %b want 0", Busy); end
        n_cmp++; if (Timeout !== 1'b1) begin n_fail++; $display("FAIL tie_timeout_pulse: got %b want 1", Timeout); end
        tick();
        n_cmp++; if (Grant_B !== 1'b1) begin n_fail++; $display("FAIL tie_second_grant_b: got %b want 1", Grant_B); end
        n_cmp++; if (Grant_A !== 1'b0) begin n_fail++; $display("FAIL tie_second_grant_a: got %b want 0", Grant_A); end
        n_cmp++; if (Pin !== 8'h22) begin n_fail++; $display("FAIL tie_second_pin: got %h want 22", Pin); end
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL tie_timeout_end: got %b want 0", Timeout); end
        Veh_A = 1'b0; Veh_B = 1'b0;
        tick();
        n_cmp++; if (Grant_B !== 1'b0) begin n_fail++; $display("FAIL tie_leave_grant_b: got %b want 0", Grant_B); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL tie_leave_busy: got %b want 0", Busy); end
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL tie_leave_no_timeout: got %b want 0", Timeout); end
    endtask

    // Lane A waits in SERVE with the gate never opening.
    task automatic test_timeout();
        Veh_A = 1'b1; Pin_A = 8'h05;
        tick();
        n_cmp++; if (Pin !== 8'h05) begin n_fail++; $display("FAIL to_serve_pin: got %h want 05", Pin); end
        n_cmp++; if (Vehiculo !== 1'b1) begin n_fail++; $display("FAIL to_serve_veh: got %b want 1", Vehiculo); end
        repeat (15) tick();
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL to_still_busy: got %b want 1", Busy); end
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL to_early_pulse: got %b want 0", Timeout); end
        tick();
        n_cmp++; if (Timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", Timeout); end
        n_cmp++; if (Grant_A !== 1'b0) begin n_fail++; $display("FAIL to_release_grant: got %b want 0", Grant_A); end
        n_cmp++; if (Pin !== 8'h00) begin n_fail++; $display("FAIL to_idle_pin: got %h want 00", Pin); end
        Veh_A = 1'b0; Pin_A = 8'h00;
        tick();
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", Timeout); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL to_after_busy: got %b want 0", Busy); end
    endtask

    // Normal open/close cycle on lane A.
    task automatic test_pass();
        Veh_A = 1'b1; Pin_A = 8'h08;
        tick();
        n_cmp++; if (Pin !== 8'h08) begin n_fail++; $display("FAIL pass_serve_pin: got %h want 08", Pin); end
        Abierto = 1'b1;
        tick();
        Abierto = 1'b0;
        #1;
        n_cmp++; if (Pin !== 8'h00) begin n_fail++; $display("FAIL pass_pin_forced: got %h want 00", Pin); end
        n_cmp++; if (Vehiculo !== 1'b1) begin n_fail++; $display("FAIL pass_veh: got %b want 1", Vehiculo); end
        n_cmp++; if (Grant_A !== 1'b1) begin n_fail++; $display("FAIL pass_grant: got %b want 1", Grant_A); end
        tick();
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL pass_hold_busy: got %b want 1", Busy); end
        Cerrado = 1'b1;
        tick();
        Cerrado = 1'b0; Veh_A = 1'b0; Pin_A = 8'h00;
        #1;
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL pass_close_busy: got %b want 0", Busy); end
        n_cmp++; if (Grant_A !== 1'b0) begin n_fail++; $display("FAIL pass_close_grant: got %b want 0", Grant_A); end
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL pass_close_timeout: got %b want 0", Timeout); end
    endtask

    // Lane B granted; lane A activity must not leak through.
    task automatic test_isolation();
        Veh_B = 1'b1; Pin_B = 8'h33;
        tick();
        n_cmp++; if (Grant_B !== 1'b1) begin n_fail++; $display("FAIL iso_grant_b: got %b want 1", Grant_B); end
        Veh_A = 1'b1; Pin_A = 8'h08;
        #1;
        n_cmp++; if (Pin !== 8'h33) begin n_fail++; $display("FAIL iso_pin: got %h want 33", Pin); end
        n_cmp++; if (Grant_A !== 1'b0) begin n_fail++; $display("FAIL iso_grant_a: got %b want 0", Grant_A); end
        tick();
        Veh_A = 1'b0;
        Veh_B = 1'b0;
        #1;
        n_cmp++; if (Vehiculo !== 1'b0) begin n_fail++; $display("FAIL iso_veh_follows_b: got %b want 0", Vehiculo); end
        Veh_B = 1'b1;
        #1;
        n_cmp++; if (Vehiculo !== 1'b1) begin n_fail++; $display("FAIL iso_veh_b_high: got %b want 1", Vehiculo); end
        Veh_B = 1'b0; Pin_A = 8'h00; Pin_B = 8'h00;
        tick();
        n_cmp++; if (Grant_B !== 1'b0) begin n_fail++; $display("FAIL iso_release_b: got %b want 0", Grant_B); end
        n_cmp++; if (Grant_A !== 1'b0) begin n_fail++; $display("FAIL iso_release_a: got %b want 0", Grant_A); end
    endtask

    // Block beats open in SERVE; LOCK holds well past the timeout.
    task automatic test_block();
        Veh_A = 1'b1; Pin_A = 8'h5A;
        tick();
        Bloqueo = 1'b1; Abierto = 1'b1;
        tick();
        n_cmp++; if (Pin !== 8'h5A) begin n_fail++; $display("FAIL blk_lock_pin: got %h want 5a", Pin); end
        Abierto = 1'b0;
        repeat (20) tick();
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL blk_hold_busy: got %b want 1", Busy); end
        n_cmp++; if (Grant_A !== 1'b1) begin n_fail++; $display("FAIL blk_hold_grant: got %b want 1", Grant_A); end
        n_cmp++; if (Pin !== 8'h5A) begin n_fail++; $display("FAIL blk_hold_pin: got %h want 5a", Pin); end
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL blk_no_timeout: got %b want 0", Timeout); end
        Bloqueo = 1'b0; Abierto = 1'b1;
        tick();
        Abierto = 1'b0;
        #1;
        n_cmp++; if (Pin !== 8'h00) begin n_fail++; $display("FAIL blk_pass_pin: got %h want 00", Pin); end
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL blk_pass_busy: got %b want 1", Busy); end
        Cerrado = 1'b1;
        tick();
        Cerrado = 1'b0; Veh_A = 1'b0; Pin_A = 8'h00;
        #1;
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL blk_idle_busy: got %b want 0", Busy); end
    endtask

    // Reset while lane B is in PASS.
    task automatic test_reset_in_pass();
        Veh_B = 1'b1; Pin_B = 8'h77;
        tick();
        Abierto = 1'b1;
        tick();
        Abierto = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        n_cmp++; if (Grant_B !== 1'b0) begin n_fail++; $display("FAIL rst_pass_grant_b: got %b want 0", Grant_B); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_pass_busy: got %b want 0", Busy); end
        n_cmp++; if (Vehiculo !== 1'b0) begin n_fail++; $display("FAIL rst_pass_veh: got %b want 0", Vehiculo); end
        n_cmp++; if (Pin !== 8'h00) begin n_fail++; $display("FAIL rst_pass_pin: got %h want 00", Pin); end
        n_cmp++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL rst_pass_timeout: got %b want 0", Timeout); end
        tick();
        n_cmp++; if (Grant_B !== 1'b1) begin n_fail++; $display("FAIL rst_resume_grant_b: got %b want 1", Grant_B); end
        n_cmp++; if (Pin !== 8'h77) begin n_fail++; $display("FAIL rst_resume_pin: got %h want 77", Pin); end
        Veh_B = 1'b0; Pin_B = 8'h00;
        tick();
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_end_busy: got %b want 0", Busy); end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_timeout();
        test_pass();
        test_isolation();
        test_block();
        test_reset_in_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
